ifmap_row_rf: RTL and testbench

- Row register file directly downstream of the ifmap FIFO.
- Accepts 64-bit row slices with a 2-bit write address and assembles complete ifmap rows into a 4-slot ring.
- Once 3 rows are resident, streams 3x3 byte windows to the PE array over a valid/ready handshake.
- Issues needRead back to the FIFO whenever a row slot is free.

---
 rtl/ifmap_row_rf.sv | 112 +++++++++++
 tb/tb_ifmap_row_rf.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_row_rf.sv
// rtl/ifmap_row_rf.sv - ifmap row register file: assembles FIFO slices into a 4-row ring and streams 3x3 windows
module ifmap_row_rf #(
    parameter int SLOTS = 4,
    parameter int PIX_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [2:0]           mode,
    input  logic                 wr_en,
    input  logic [1:0]           wr_addr,
    input  logic [8*PIX_W-1:0]   wr_data,
    output logic                 needRead,
    output logic                 win_valid,
    input  logic                 win_ready,
    output logic [9*PIX_W-1:0]   win_data,
    output logic [4:0]           win_col,
    output logic                 row_done,
    output logic [2:0]           rows_held,
    output logic                 overflow
);
    localparam int PW      = $clog2(SLOTS);
    localparam int SLICE_W = 8 * PIX_W;
    localparam int ROW_W   = 4 * SLICE_W;
    localparam int BW      = $clog2(ROW_W);

    logic [SLICE_W-1:0] mem [SLOTS][4];
    logic [PW-1:0]      head;
    logic [PW-1:0]      fill;
    logic [2:0]         held;
    logic [4:0]         col;

    logic       mode_ok;
    logic [1:0] last_addr;
    logic [4:0] last_col;
    logic       xfer;
    logic       retire;
    logic       accept;
    logic       commit;
    logic       drop;

    assign mode_ok   = (mode <= 3'd1);
    assign last_addr = (mode == 3'd0) ? 2'd2 : 2'd0;
    assign last_col  = (mode == 3'd0) ? 5'd27 : 5'd11;

    assign needRead  = mode_ok && (held < 3'(SLOTS));
    assign win_valid = mode_ok && (held >= 3'd3);

    assign xfer   = win_valid && win_ready;
    assign retire = xfer && (col == last_col);
    assign accept = mode_ok && wr_en && (held < 3'(SLOTS));
    assign commit = accept && (wr_addr == last_addr);
    assign drop   = mode_ok && wr_en && (held == 3'(SLOTS));

    // Rows are laid out in pixel order: slice address 3 holds the leftmost pixels.
    for (genvar r = 0; r < 3; r++) begin : g_row
        logic [PW-1:0]    slot;
        logic [ROW_W-1:0] px;
        assign slot = head + PW'(r);
        assign px   = {mem[slot][2], mem[slot][1], mem[slot][0], mem[slot][3]};
        for (genvar c = 0; c < 3; c++) begin : g_col
            logic [5:0]    idx;
            logic [BW-1:0] base;
            assign idx  = {1'b0, col} + 6'(c);
            assign base = BW'(int'(idx) * PIX_W);
            assign win_data[PIX_W*(3*r+c) +: PIX_W] = px[base +: PIX_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            head     <= '0;
            fill     <= '0;
            held     <= 3'd0;
            col      <= 5'd0;
            overflow <= 1'b0;
            row_done <= 1'b0;
            for (int s = 0; s < SLOTS; s++) begin
                for (int a = 0; a < 4; a++) begin
                    mem[s][a] <= '0;
                end
            end
        end else begin
            row_done <= retire;
            if (accept) begin
                mem[fill][wr_addr] <= wr_data;
            end
            if (commit) begin
                fill <= fill + PW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (xfer) begin
                col <= retire ? 5'd0 : col + 5'd1;
            end
            if (retire) begin
                head <= head + PW'(1);
            end
            // A commit and a retire in the same cycle cancel in the row count.
            case ({commit, retire})
                2'b10:   held <= held + 3'd1;
                2'b01:   held <= held - 3'd1;
                default: held <= held;
            endcase
        end
    end

    assign win_col   = col;
    assign rows_held = held;

endmodule

// File: tb/tb_ifmap_row_rf.sv
// tb/tb_ifmap_row_rf.sv - directed plus randomized bench for ifmap_row_rf against a row-queue model
module tb_ifmap_row_rf;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = 2'd0;
    logic [63:0] wr_data = 64'd0;
    logic        win_ready = 1'b0;
    logic        needRead;
    logic        win_valid;
    logic [71:0] win_data;
    logic [4:0]  win_col;
    logic        row_done;
    logic [2:0]  rows_held;
    logic        overflow;

    ifmap_row_rf dut (
        .clk(clk), .rst(rst), .clear(clear), .mode(mode),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .needRead(needRead), .win_valid(win_valid), .win_ready(win_ready),
        .win_data(win_data), .win_col(win_col), .row_done(row_done),
        .rows_held(rows_held), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;

    // Model: queue of complete rows (pixel p at bits [8p+:8]), the row being filled, column, flags.
    logic [255:0] q[$];
    logic [255:0] part;
    int           wc;
    bit           ovf;
    bit           rd;
    int           wq[$];

    function automatic int first_px(input logic [1:0] a);
        case (a)
            2'd3:    return 0;
            2'd0:    return 8;
            2'd1:    return 16;
            default: return 24;
        endcase
    endfunction

    function automatic logic [63:0] slice(input int r, input int a);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(r * 32 + first_px(2'(a)) + k);
        return d;
    endfunction

    function automatic logic [71:0] exp_win();
        logic [71:0]  w;
        logic [255:0] rv;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            rv = q[r];
            for (int c = 0; c < 3; c++) w[8*(3*r+c) +: 8] = rv[8*(wc+c) +: 8];
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_step();
        bit ok, xf, ret, com;
        int w;
        if (!rst || clear) begin
            q.delete();
            part = '0;
            wc = 0;
            ovf = 0;
            rd = 0;
        end else begin
            ok  = (mode <= 3'd1);
            w   = (mode == 3'd0) ? 30 : 14;
            xf  = ok && (q.size() >= 3) && win_ready;
            ret = xf && (wc == w - 3);
            com = 0;
            if (ok && wr_en) begin
                if (q.size() < 4) begin
                    part[first_px(wr_addr)*8 +: 64] = wr_data;
                    com = (wr_addr == ((mode == 3'd0) ? 2'd2 : 2'd0));
                end else begin
                    ovf = 1;
                end
            end
            if (xf) wc = ret ? 0 : wc + 1;
            if (ret) void'(q.pop_front());
            if (com) q.push_back(part);
            rd = ret;
        end
    endtask

    task automatic check_all();
        bit ok;
        ok = (mode <= 3'd1);
        chk("rows_held", rows_held, q.size());
        chk("needRead", needRead, ok && (q.size() < 4));
        chk("win_valid", win_valid, ok && (q.size() >= 3));
        chk("win_col", win_col, wc);
        chk("row_done", row_done, rd);
        chk("overflow", overflow, ovf);
        if (ok && q.size() >= 3) chk("win_data", win_data, exp_win());
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input bit we, input int a, input logic [63:0] d);
        wr_en = we;
        wr_addr = 2'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 64'd0);
    endtask

    task automatic write_row(input int r);
        if (mode == 3'd0) begin
            drive(1, 3, slice(r, 3));
            drive(1, 0, slice(r, 0));
            drive(1, 1, slice(r, 1));
            drive(1, 2, slice(r, 2));
        end else begin
            drive(1, 3, slice(r, 3));
            drive(1, 0, slice(r, 0));
        end
    endtask

    task automatic new_seq();
        int a[3];
        int t, j;
        wq.delete();
        if (mode == 3'd0) begin
            a = '{3, 0, 1};
            j = int'($urandom_range(2));
            t = a[0]; a[0] = a[j]; a[j] = t;
            j = 1 + int'($urandom_range(1));
            t = a[1]; a[1] = a[j]; a[j] = t;
            foreach (a[i]) wq.push_back(a[i]);
            if ($urandom_range(3) == 0) wq.push_back(a[$urandom_range(2)]);
            wq.push_back(2);
        end else begin
            wq.push_back(3);
            if ($urandom_range(3) == 0) wq.push_back(3);
            wq.push_back(0);
        end
    endtask

    initial begin
        bit acc;
        // Reset state
        rst = 1'b0;
        idle(1);
        chk("reset_needRead", needRead, 1'b1);
        chk("reset_win_valid", win_valid, 1'b0);
        rst = 1'b1;

        // Three rows in mode 0, then the first window
        write_row(0);
        write_row(1);
        write_row(2);
        chk("first_valid", win_valid, 1'b1);
        chk("first_window", win_data, 72'h42_41_40_22_21_20_02_01_00);
        chk("first_needRead", needRead, 1'b1);

        // 28 transfers retire row 0
        win_ready = 1'b1;
        idle(28);
        chk("retire_row_done", row_done, 1'b1);
        chk("retire_rows_held", rows_held, 3'd2);
        chk("retire_valid", win_valid, 1'b0);

        // Commit in the same cycle as the last transfer of a row
        win_ready = 1'b0;
        write_row(3);
        drive(1, 3, slice(4, 3));
        drive(1, 0, slice(4, 0));
        drive(1, 1, slice(4, 1));
        win_ready = 1'b1;
        idle(27);
        chk("pre_sim_col", win_col, 5'd27);
        drive(1, 2, slice(4, 2));
        chk("sim_rows_held", rows_held, 3'd3);
        chk("sim_valid", win_valid, 1'b1);
        chk("sim_col", win_col, 5'd0);
        chk("sim_window", win_data, 72'h82_81_80_62_61_60_42_41_40);

        // Fill the ring, then a dropped write
        win_ready = 1'b0;
        write_row(5);
        chk("full_needRead", needRead, 1'b0);
        drive(1, 3, slice(6, 3));
        chk("full_overflow", overflow, 1'b1);
        chk("full_rows_held", rows_held, 3'd4);

        // Reset mid-stream with a partial row
        win_ready = 1'b1;
        idle(43);
        chk("mid_col", win_col, 5'd15);
        win_ready = 1'b0;
        drive(1, 3, slice(7, 3));
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        chk("rst_rows_held", rows_held, 3'd0);
        chk("rst_valid", win_valid, 1'b0);
        chk("rst_needRead", needRead, 1'b1);
        chk("rst_overflow", overflow, 1'b0);

        // Same again with clear
        write_row(0);
        write_row(1);
        write_row(2);
        write_row(3);
        drive(1, 3, slice(4, 3));
        win_ready = 1'b1;
        idle(43);
        win_ready = 1'b0;
        drive(1, 3, slice(5, 3));
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        chk("clr_rows_held", rows_held, 3'd0);
        chk("clr_valid", win_valid, 1'b0);
        chk("clr_needRead", needRead, 1'b1);
        chk("clr_overflow", overflow, 1'b0);

        // Mode 1: 14-pixel rows, last window at column 11
        mode = 3'd1;
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        write_row(0);
        write_row(1);
        write_row(2);
        win_ready = 1'b1;
        idle(11);
        chk("m1_last_col", win_col, 5'd11);
        chk("m1_last_window", win_data, 72'h4d_4c_4b_2d_2c_2b_0d_0c_0b);
        idle(1);
        chk("m1_row_done", row_done, 1'b1);
        chk("m1_rows_held", rows_held, 3'd2);

        // Randomized traffic
        wq.delete();
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(499) != 0);
            clear = ($urandom_range(249) == 0);
            if (clear) begin
                mode = ($urandom_range(7) == 0) ? 3'($urandom_range(7, 2)) : 3'($urandom_range(1));
                wq.delete();
            end
            if (!rst) wq.delete();
            win_ready = ($urandom_range(2) != 0);
            wr_en = ($urandom_range(2) == 0);
            if (mode <= 3'd1) begin
                if (wq.size() == 0) new_seq();
                wr_addr = 2'(wq[0]);
            end else begin
                wr_addr = 2'($urandom_range(3));
            end
            wr_data = {$urandom, $urandom};
            acc = wr_en && rst && !clear && (mode <= 3'd1) && (q.size() < 4);
            tick();
            if (acc) void'(wq.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
